// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard controller <-> datapath signal bundle.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic [OP_W-1:0]  ifid_opcode;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rd;
  logic             branch_taken;
  logic             imem_busy;
  logic             dmem_busy;
  logic             pc_wen;
  logic             ifid_wen;
  logic             idex_wen;
  logic             exmem_wen;
  logic             memwb_wen;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output ifid_opcode, ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rd,
           branch_taken, imem_busy, dmem_busy,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles, flush_count
  );
  modport slave (
    input  ifid_opcode, ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rd,
           branch_taken, imem_busy, dmem_busy,
    output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/halt sequencer for the 4-latch CPU.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int              REG_W        = 4,
  parameter int              OP_W         = 4,
  parameter logic [OP_W-1:0] HLT_OPCODE   = 4'hF,
  parameter int              DRAIN_CYCLES = 3,
  parameter int              CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [4:0] wen;
  logic [3:0] flush;
  logic load_use;
  assign load_use = bus.idex_memread && bus.idex_rd != REG_W'(0) &&
                    (bus.idex_rd == bus.ifid_rs || (bus.ifid_uses_rt && bus.idex_rd == bus.ifid_rt));
  // wen = {pc, ifid, idex, exmem, memwb}; flush = {ifid, idex, exmem, memwb}
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wen = {5{state_q != HALTED}};
    flush = '0;
    if (!rst_n) begin
      wen = '0;
      flush = '1;
    end else if (state_q != HALTED) begin
      if (bus.dmem_busy) begin
        wen[4:1] = '0;
        flush[0] = 1'b1;
      end else if (bus.imem_busy) begin
        wen[4] = 1'b0;
        flush[3] = 1'b1;
      end else if (load_use) begin
        wen[4:3] = '0;
        flush[2] = 1'b1;
      end else if (state_q == RUN && bus.ifid_opcode == HLT_OPCODE) begin
        wen[4] = 1'b0;
        flush[3] = 1'b1;
        state_d = DRAIN;
        drain_d = DW'(DRAIN_CYCLES);
      end else if (state_q == RUN && bus.branch_taken) begin
        flush[3] = 1'b1;
      end
      if (state_q == DRAIN) begin
        wen[4] = 1'b0;
        flush[3] = 1'b1;
        drain_d = bus.dmem_busy ? drain_q : drain_q - 1'b1;
        state_d = (!bus.dmem_busy && drain_q == DW'(1)) ? HALTED : DRAIN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  assign {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen, bus.memwb_wen} = wen;
  assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = flush;
  assign bus.halted = state_q == HALTED;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q != HALTED) begin
      if (!wen[4] && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (|flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count = flush_q;
`else
  assign bus.stall_cycles = CNT_W'(0);
  assign bus.flush_count = CNT_W'(0);
`endif
endmodule
